// File: rtl/bram_stream_reader.sv
// Burst reader for a registered-output block RAM.
// Accepts a (base, length) request, walks the RAM address space with
// wrap-around and presents the words as a valid/ready stream through a
// two-entry buffer that hides the RAM's one-cycle read latency.
//
// Stream handshake: a word moves from this block to the consumer on every
// rising edge where valid_o and ready_i are both high. Once valid_o rises it
// stays high, with data_o unchanged, until that transfer happens.
module bram_stream_reader #(
  parameter int memSize_p   = 8,
  parameter int dataWidth_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [memSize_p-1:0]   base_addr_i,
  input  logic [memSize_p:0]     length_i,
  output logic [memSize_p-1:0]   raddr_o,
  input  logic [dataWidth_p-1:0] rdata_i,
  output logic [dataWidth_p-1:0] data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [memSize_p-1:0]   raddr_q;
  logic [memSize_p:0]     remaining_q;
  logic                   inflight_q;
  logic [1:0]             occ_q;
  logic [dataWidth_p-1:0] head_q;
  logic [dataWidth_p-1:0] tail_q;

  logic       pop;
  logic       push;
  logic [2:0] level;
  logic       issue;
  logic       last_pop;

  // Handshake, issue throttle and end-of-burst detection.
  always_comb begin
    pop      = (occ_q != 2'd0) && ready_i;
    push     = inflight_q;
    // Words that will be held once this cycle's pop completes; a pop implies occ_q >= 1.
    level    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue    = (state_q == READ) && (remaining_q != '0) && (level < 3'd2);
    last_pop = (state_q == READ) && (remaining_q == '0) && !inflight_q &&
               (occ_q == 2'd1) && pop;
  end

  // Next-state logic for the burst controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (length_i == '0) ? FINISH : READ;
        end
      end
      READ: begin
        if (last_pop) begin
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Address, remaining count and in-flight tracking.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      raddr_q     <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      inflight_q <= issue;
      if ((state_q == IDLE) && start_i) begin
        raddr_q     <= base_addr_i;
        remaining_q <= length_i;
      end else if (issue) begin
        // Natural overflow of the address register gives the wrap to 0.
        raddr_q     <= raddr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
    end
  end

  // Two-entry buffer: head_q drives data_o directly, tail_q holds the second word.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (occ_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= rdata_i;
          end else begin
            head_q <= rdata_i;
          end
        end
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_q <= rdata_i;
          end else begin
            tail_q <= rdata_i;
          end
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          // With one word left the head keeps its value after the pop.
          if (occ_q == 2'd2) begin
            head_q <= tail_q;
          end
          occ_q <= occ_q - 2'd1;
        end
        default: begin
          occ_q <= occ_q;
        end
      endcase
    end
  end

  assign raddr_o = raddr_q;
  assign data_o  = head_q;
  assign valid_o = (occ_q != 2'd0);
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == FINISH);
  assign state_o = state_q;

endmodule
